// File: rtl/hazard_unit.sv
// ============================================================================
//  Module      : hazard_unit
//  Description : Stall/flush controller for the 5-stage MIPS pipeline:
//                load-use interlock, taken-branch flush, MULT/DIV sequencing
//                with HI/LO interlock, and a saturating stall-cycle counter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_unit #(
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdE,
    input  logic             memreadE,
    input  logic             pcsrcE,
    input  logic             mdstartE,
    input  logic             mdopD,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             mdbusy,
    output logic             mddone,
    output logic [CNT_W-1:0] stallcnt
);

    localparam int unsigned MDC_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam logic [MDC_W-1:0] c_md_load = MDC_W'(MD_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    md_state_t        r_state;
    logic [MDC_W-1:0] r_mdcnt;
    logic             r_mdbusy;
    logic             r_mddone;
    logic [CNT_W-1:0] r_stallcnt;

    logic w_lwstall;
    logic w_mdstall;
    logic w_stall;
    logic w_flushD;

    // A load writing $0 never produces a real dependency.
    assign w_lwstall = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    assign w_mdstall = r_mdbusy && mdopD;

    // Taken branch wins: the instruction in ID is wrong-path, so flush rather than hold it.
    assign w_stall  = (w_lwstall || w_mdstall) && !pcsrcE && !rst;
    assign w_flushD = pcsrcE && !rst;

    assign stallF   = w_stall;
    assign stallD   = w_stall;
    assign flushD   = w_flushD;
    assign flushE   = w_stall || w_flushD;
    assign mdbusy   = r_mdbusy;
    assign mddone   = r_mddone;
    assign stallcnt = r_stallcnt;

    // MD sequencer: mdbusy spans MD_CYCLES cycles after the start, the last being DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mdcnt  <= '0;
            r_mdbusy <= 1'b0;
            r_mddone <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdstartE) begin
                        r_state  <= S_BUSY;
                        r_mdcnt  <= c_md_load;
                        r_mdbusy <= 1'b1;
                        r_mddone <= (c_md_load == '0) ? 1'b0 : 1'b0;
                    end
                end
                S_BUSY: begin
                    if (r_mdcnt == '0) begin
                        r_state  <= S_DONE;
                        r_mddone <= 1'b1;
                    end else begin
                        r_mdcnt <= r_mdcnt - MDC_W'(1);
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_mdbusy <= 1'b0;
                    r_mddone <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mdcnt  <= '0;
                    r_mdbusy <= 1'b0;
                    r_mddone <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallcnt <= '0;
        end else if (w_stall && (r_stallcnt != c_cnt_max)) begin
            r_stallcnt <= r_stallcnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Stall/flush controller for the 5-stage MIPS pipeline. The forwarding path resolves hazards by steering operands into EX. This block handles the hazards that forwarding cannot resolve:
- holds IF/ID for load-use dependencies
- flushes wrong-path instructions on taken branches/jumps resolved in EX
- sequences the multi-cycle MULT/DIV unit and interlocks HI/LO consumers until it completes
It also keeps a saturating stall-cycle performance counter.

Parameters:
MD_CYCLES, 32, EX cycles the MULT/DIV unit occupies per operation (legal range 2..255)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
rs1D  input  5  source register 1 of instruction in ID
rs2D  input  5  source register 2 of instruction in ID
rdE  input  5  destination register of instruction in EX
memreadE  input  1  instruction in EX is a load
pcsrcE  input  1  branch/jump in EX resolved taken
mdstartE  input  1  instruction in EX is MULT/DIV, starts MD unit this cycle
mdopD  input  1  instruction in ID reads HI/LO or issues MULT/DIV
stallF  output  1  hold PC
stallD  output  1  hold IF/ID register
flushD  output  1  clear IF/ID register (bubble)
flushE  output  1  clear ID/EX register (bubble)
mdbusy  output  1  MD unit occupied
mddone  output  1  one-cycle pulse: MD result written to HI/LO at end of this cycle
stallcnt  output  CNT_W  cycles with stallD=1 since reset, saturating

Behaviour:
- Reset (asynchronous, active-high):
  - While rst=1, stallF, stallD, flushD, flushE, mdbusy and mddone are 0.
  - FSM goes to IDLE; MD counter and stallcnt are cleared to 0.
  - Reset asserted mid-operation aborts any MD operation immediately.
- Load-use (combinational): lwstall = memreadE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- MD interlock (combinational): mdstall = mdbusy && mdopD.
- stall = (lwstall || mdstall) && !pcsrcE.
- stallF = stallD = stall.
- flushE = stall || pcsrcE.
- flushD = pcsrcE.
- pcsrcE has priority: a wrong-path instruction in ID is flushed, never stalled.
- A load-use stall lasts exactly 1 cycle. The bubble then moves the load to MEM and forwarding covers the dependency.
- MD FSM states:
  - IDLE: mdbusy=0, mddone=0. If mdstartE=1, load counter with MD_CYCLES-2 and go to BUSY.
  - BUSY: mdbusy=1. Counter decrements by 1 each cycle. When counter==0, go to DONE.
  - DONE: mdbusy=1, mddone=1. Go to IDLE on the next edge.
- MD timing:
  - From the mdstartE cycle, mdbusy is high for MD_CYCLES cycles, the last of which is the mddone cycle.
  - mdstall is therefore still asserted during DONE. A HI/LO consumer issues in the first IDLE cycle and reads the written value.
- mdstartE in BUSY/DONE is ignored; the mdopD interlock makes it unreachable.
- mdstartE in the same cycle as pcsrcE: the start is accepted, because the MD op is in EX and is not on the wrong path.
- pcsrcE while BUSY: flushD/flushE assert as normal; the FSM continues unaffected.
- lwstall and mdstall together: a single combined stall, with flushE=1.
- stallcnt:
  - Increments by 1 on each rising edge where stallD=1.
  - Holds at 2^CNT_W-1 (no wrap).
  - Registered; it reflects the stalls of previous cycles.
- The counter width for MD is ceil(log2(MD_CYCLES)) bits, minimum 1. All compares on register numbers are 5-bit equality.

Test Plan:
- Load-use hazard: memreadE=1, rdE=5, rs1D=5 for 1 cycle → stallF=stallD=flushE=1, flushD=0 that cycle; stallcnt goes 0→1 at the next edge.
- Load to $0: memreadE=1, rdE=0, rs1D=0 → all stall/flush outputs 0; stallcnt stays 0.
- Taken branch with load match in ID: pcsrcE=1 while memreadE=1, rdE=rs2D=7 → flushD=flushE=1, stallF=stallD=0.
- MD sequencing with MD_CYCLES=4:
  - mdstartE pulse at cycle t → mdbusy=1 for cycles t+1..t+4, mddone=1 only at t+4, IDLE at t+5.
  - Holding mdopD=1 gives stallD=1 for t+1..t+4 and 0 at t+5; stallcnt=4.
- Reset mid-MD: assert rst at BUSY cycle t+2, asynchronously between edges → mdbusy, stallD, flushE and stallcnt drop to 0 immediately, before the next edge. After release, mdopD=1 causes no stall.
- Counter saturation with CNT_W=4: hold a continuous mdstall for 20 cycles → stallcnt reaches 15 and holds at 15.
